ascon_aead_sequencer: RTL

Stream-side controller that sequences one `ASCON_AEAD` core through a complete AEAD operation. It accepts a key/nonce command, then associated-data (AD) and message blocks over valid/ready handshakes. It drives the core's `start`/`mode`/`blockin`/`datalen` with the fixed per-phase cycle budgets, and returns ciphertext/plaintext blocks and the tag. It sits between the system bus/DMA front end and the core, and removes all cycle counting from software and benches.

---
 rtl/ascon_aead_sequencer_if.sv | 48 ++++
 rtl/ascon_aead_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ascon_aead_sequencer_if.sv
// Stream-side bus of the ASCON AEAD sequencer.
// Carries the command handshake, the AD/message beat handshake, the output
// block pulse, the tag pulse and the status flags.
//   master : system bus / DMA front end (drives cmd_* and in_*)
//   slave  : ascon_aead_sequencer (drives cmd_ready, in_ready, out_*, tag*, busy, err)
interface ascon_aead_sequencer_if;
  localparam int unsigned KEY_W = 128;
  localparam int unsigned BLK_W = 64;
  localparam int unsigned LEN_W = 4;

  // command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_encrypt;
  logic             cmd_has_ad;
  logic [KEY_W-1:0] cmd_key;
  logic [KEY_W-1:0] cmd_nonce;

  // data beat channel (byte 0 in the most significant byte)
  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic             in_last;

  // result pulses and status
  logic             out_valid;
  logic [BLK_W-1:0] out_data;
  logic [LEN_W-1:0] out_len;
  logic             tag_valid;
  logic [KEY_W-1:0] tag;
  logic             busy;
  logic             err;

  modport master (
    output cmd_valid, cmd_encrypt, cmd_has_ad, cmd_key, cmd_nonce,
    output in_valid, in_data, in_len, in_last,
    input  cmd_ready, in_ready,
    input  out_valid, out_data, out_len, tag_valid, tag, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_encrypt, cmd_has_ad, cmd_key, cmd_nonce,
    input  in_valid, in_data, in_len, in_last,
    output cmd_ready, in_ready,
    output out_valid, out_data, out_len, tag_valid, tag, busy, err
  );
endinterface

// File: rtl/ascon_aead_sequencer.sv
// Sequences one ASCON_AEAD core through a full AEAD operation: command
// accept, initialization, AD blocks (with the extra padding block when the
// last AD block is full), message blocks and finalization. All cycle
// counting for the core lives here.
// Ports:
//   clk, nRST         clock, synchronous active-low reset
//   bus (slave)       command / beat / result / status stream side
//   core_start        high for the A initialization cycles
//   core_mode         {has_ad, encrypt} captured at command accept
//   core_key/nonce    captured at command accept
//   core_blockin      registered beat data
//   core_datalen      registered beat length, 0 during padding blocks
//   core_Tag, core_CTblock, core_CTv, core_Tv   results from the core
module ascon_aead_sequencer #(
  parameter int unsigned A = 12,
  parameter int unsigned B = 6
) (
  input  logic                  clk,
  input  logic                  nRST,
  ascon_aead_sequencer_if.slave bus,
  output logic                  core_start,
  output logic [1:0]            core_mode,
  output logic [127:0]          core_key,
  output logic [127:0]          core_nonce,
  output logic [63:0]           core_blockin,
  output logic [3:0]            core_datalen,
  input  logic [127:0]          core_Tag,
  input  logic [63:0]           core_CTblock,
  input  logic                  core_CTv,
  input  logic                  core_Tv
);

  localparam int unsigned BLK_W   = 64;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_MAX = (A > B) ? A : B;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned FULL    = 8;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INIT     = 4'd1,
    AD_WAIT  = 4'd2,
    AD_PERM  = 4'd3,
    AD_PAD   = 4'd4,
    MSG_WAIT = 4'd5,
    MSG_PERM = 4'd6,
    FINAL    = 4'd7,
    DONE     = 4'd8
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_q;

  logic cmd_fire;
  logic in_fire;
  logic beat_bad;
  logic beat_ok;
  logic cnt_a_done;
  logic cnt_b_done;
  logic len_full;

  // Keep bytes 0..len-1 (byte 0 is the MSB); len >= 8 keeps everything.
  function automatic logic [BLK_W-1:0] byte_mask(input logic [LEN_W-1:0] len);
    if (len >= LEN_W'(FULL)) begin
      byte_mask = '1;
    end else begin
      byte_mask = ~({BLK_W{1'b1}} >> {len, 3'b000});
    end
  endfunction

  // Handshake qualification and phase-counter terminal counts.
  always_comb begin
    cmd_fire   = bus.cmd_valid && bus.cmd_ready && (state == IDLE);
    in_fire    = bus.in_valid && bus.in_ready &&
                 ((state == AD_WAIT) || (state == MSG_WAIT));
    // Zero-length beats are only legal as the final message beat.
    beat_bad   = in_fire &&
                 ((bus.in_len > LEN_W'(FULL)) ||
                  ((bus.in_len == '0) && ((state == AD_WAIT) || !bus.in_last)));
    beat_ok    = in_fire && !beat_bad;
    cnt_a_done = (cnt == CNT_W'(A - 1));
    cnt_b_done = (cnt == CNT_W'(B - 1));
    len_full   = (core_datalen == LEN_W'(FULL));
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire) state_nxt = INIT;
      end
      INIT: begin
        if (cnt_a_done) state_nxt = core_mode[1] ? AD_WAIT : MSG_WAIT;
      end
      AD_WAIT: begin
        if (beat_ok) state_nxt = AD_PERM;
      end
      AD_PERM: begin
        if (cnt_b_done) begin
          if (!last_q)       state_nxt = AD_WAIT;
          else if (len_full) state_nxt = AD_PAD;
          else               state_nxt = MSG_WAIT;
        end
      end
      AD_PAD: begin
        if (cnt_b_done) state_nxt = MSG_WAIT;
      end
      MSG_WAIT: begin
        if (beat_ok) state_nxt = MSG_PERM;
      end
      MSG_PERM: begin
        // A short final block needs no permutation before finalization.
        if (last_q && !len_full && (cnt == '0)) state_nxt = FINAL;
        else if (cnt_b_done)                    state_nxt = last_q ? FINAL : MSG_WAIT;
      end
      FINAL: begin
        if (cnt_a_done) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, phase counter and every registered output.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state         <= IDLE;
      cnt           <= '0;
      last_q        <= 1'b0;
      core_start    <= 1'b0;
      core_mode     <= '0;
      core_key      <= '0;
      core_nonce    <= '0;
      core_blockin  <= '0;
      core_datalen  <= '0;
      bus.cmd_ready <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_len   <= '0;
      bus.tag_valid <= 1'b0;
      bus.tag       <= '0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      // Counter restarts on every state change, so each phase counts from 0.
      cnt           <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      bus.cmd_ready <= (state_nxt == IDLE);
      bus.in_ready  <= (state_nxt == AD_WAIT) || (state_nxt == MSG_WAIT);
      bus.busy      <= (state_nxt != IDLE);
      bus.out_valid <= 1'b0;
      bus.tag_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_fire) begin
            core_key   <= bus.cmd_key;
            core_nonce <= bus.cmd_nonce;
            core_mode  <= {bus.cmd_has_ad, bus.cmd_encrypt};
            core_start <= 1'b1;
            bus.err    <= 1'b0;
            bus.tag    <= '0;
          end
        end
        INIT: begin
          if (cnt_a_done) core_start <= 1'b0;
        end
        AD_WAIT, MSG_WAIT: begin
          if (beat_ok) begin
            core_blockin <= bus.in_data;
            core_datalen <= bus.in_len;
            last_q       <= bus.in_last;
          end
          if (beat_bad) bus.err <= 1'b1;
        end
        AD_PERM: begin
          // A full last AD block is followed by an empty padding block.
          if (cnt_b_done && last_q && len_full) core_datalen <= '0;
        end
        MSG_PERM: begin
          if (cnt == '0) begin
            bus.out_data  <= core_CTblock & byte_mask(core_datalen);
            bus.out_len   <= core_datalen;
            bus.out_valid <= 1'b1;
            if (!core_CTv) bus.err <= 1'b1;
          end
          if (cnt_b_done && last_q && len_full) core_datalen <= '0;
        end
        FINAL: begin
          if (cnt_a_done) begin
            bus.tag       <= core_Tag;
            bus.tag_valid <= 1'b1;
            if (!core_Tv) bus.err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
